// File: rtl/wb_write_queue.sv
// Writeback write queue: buffers register-file writes while the write port is
// stalled, drains them in order, and forwards pending values to decode lookups.
module wb_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     InValid,
  input  logic [4:0]               InRD,
  input  logic [WIDTH-1:0]         InData,
  output logic                     InReady,
  input  logic                     WbStall,
  output logic                     RegWrite,
  output logic [4:0]               RD,
  output logic [WIDTH-1:0]         WriteData,
  input  logic [4:0]               RS1,
  input  logic [4:0]               RS2,
  output logic                     Hit1,
  output logic                     Hit2,
  output logic [WIDTH-1:0]         FwdData1,
  output logic [WIDTH-1:0]         FwdData2,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Full,
  output logic                     Empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [4:0]       rd_mem_d   [DEPTH];
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];

  logic             full_c;
  logic             empty_c;
  logic             push_c;
  logic             pop_c;

  // Pointer, occupancy and storage next-state
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;

    full_c  = (count_q == CNT_W'(DEPTH));
    empty_c = (count_q == '0);
    // x0 requests are accepted but never stored
    push_c  = InValid && !full_c && (InRD != 5'd0);
    pop_c   = !empty_c && !WbStall;

    if (push_c) begin
      rd_mem_d[tail_q]   = InRD;
      data_mem_d[tail_q] = InData;
      tail_d             = tail_q + PTR_W'(1);
    end
    if (pop_c) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides validity
  always_ff @(posedge Clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

  logic [PTR_W-1:0] idx_c;
  logic             hit1_c;
  logic             hit2_c;
  logic [WIDTH-1:0] fwd1_c;
  logic [WIDTH-1:0] fwd2_c;

  // Walk oldest to youngest so the youngest match overwrites earlier ones
  always_comb begin
    idx_c  = '0;
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    fwd1_c = '0;
    fwd2_c = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx_c = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if ((RS1 != 5'd0) && (rd_mem_q[idx_c] == RS1)) begin
          hit1_c = 1'b1;
          fwd1_c = data_mem_q[idx_c];
        end
        if ((RS2 != 5'd0) && (rd_mem_q[idx_c] == RS2)) begin
          hit2_c = 1'b1;
          fwd2_c = data_mem_q[idx_c];
        end
      end
    end
  end

  // Write-port and lookup outputs are forced quiet while reset is asserted
  always_comb begin
    InReady   = !full_c;
    Full      = full_c;
    Empty     = empty_c;
    Count     = count_q;
    RegWrite  = Reset ? 1'b0 : pop_c;
    RD        = (Reset || empty_c) ? 5'd0 : rd_mem_q[head_q];
    WriteData = (Reset || empty_c) ? '0 : data_mem_q[head_q];
    Hit1      = Reset ? 1'b0 : hit1_c;
    Hit2      = Reset ? 1'b0 : hit2_c;
    FwdData1  = Reset ? '0 : fwd1_c;
    FwdData2  = Reset ? '0 : fwd2_c;
  end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the queue entry count (power of two, 2..16).
REQ-002 Parameter WIDTH, default 64, SHALL set the data width of every entry.
REQ-003 Port Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port Reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 Port InValid  input  1  SHALL mark a writeback request present this cycle.
REQ-006 Port InRD  input  5  SHALL carry the destination register of the request.
REQ-007 Port InData  input  WIDTH  SHALL carry the result value of the request.
REQ-008 Port InReady  output  1  SHALL indicate the queue accepts a request this cycle.
REQ-009 Port WbStall  input  1  SHALL indicate the register-file write port is unavailable this cycle.
REQ-010 Port RegWrite  output  1  SHALL be the register-file write enable.
REQ-011 Port RD  output  5  SHALL be the register-file write address.
REQ-012 Port WriteData  output  WIDTH  SHALL be the register-file write data.
REQ-013 Ports RS1, RS2  input  5 each  SHALL be the decode-stage source registers to look up.
REQ-014 Ports Hit1, Hit2  output  1 each  SHALL flag a pending queued write to RS1 / RS2.
REQ-015 Ports FwdData1, FwdData2  output  WIDTH each  SHALL return the pending value for RS1 / RS2.
REQ-016 Ports Count  output  $clog2(DEPTH)+1; Full, Empty  output  1 each  SHALL report occupancy.

Function
REQ-017 Queue SHALL be a circular FIFO (head/tail pointers wrap at DEPTH-1 to 0) of {rd, data} entries.
REQ-018 InReady SHALL equal !Full combinationally; Full = (Count == DEPTH), Empty = (Count == 0).
REQ-019 Accept SHALL occur when InValid && InReady; if InRD != 0, the entry SHALL be written at tail and tail advanced.
REQ-020 Accepted request with InRD == 0 SHALL be consumed and dropped: no entry, no Count change.
REQ-021 InValid while Full SHALL NOT alter state; the requester holds the request.
REQ-022 RegWrite SHALL equal !Empty && !WbStall; RD/WriteData SHALL show the head entry when !Empty, else 0.
REQ-023 Pop SHALL occur when RegWrite is 1, advancing head at the clock edge.
REQ-024 Simultaneous push and pop SHALL leave Count unchanged; push alone increments it, pop alone decrements it.
REQ-025 A request accepted into an empty queue SHALL appear on RegWrite/RD/WriteData the next cycle (latency 1).
REQ-026 Order SHALL be preserved: writes leave in acceptance order.
REQ-027 Lookup SHALL be combinational over all occupied entries, including the head being written this cycle.
REQ-028 Multiple matching entries SHALL resolve to the youngest (closest to tail).
REQ-029 RSx == 0 SHALL never hit; on no hit, Hitx = 0 and FwdDatax = 0.
REQ-030 A request being accepted this cycle SHALL NOT be visible to lookup until the next cycle.

Reset
REQ-031 Reset = 1 at a rising edge SHALL clear head, tail and Count, giving Empty = 1, Full = 0, InReady = 1.
REQ-032 During and after reset, RegWrite, RD, WriteData, Hit1/2 and FwdData1/2 SHALL be 0; entry storage need not be cleared.
REQ-033 Reset SHALL take priority over a simultaneous push or pop; mid-operation entries are discarded.

Verification
REQ-034 Single write: push rd=5, data=0xAA, WbStall=0 -> next cycle RegWrite=1, RD=5, WriteData=0xAA; cycle after, Empty=1.
REQ-035 Fill and stall: WbStall=1, push rd=1..4 with data 0x11..0x44 -> Count=4, Full=1, InReady=0; fifth push ignored; release WbStall -> writes 1,2,3,4 in order over four cycles.
REQ-036 Forwarding priority: WbStall=1, push (rd=7, 0x10) then (rd=7, 0x20); RS1=7 -> Hit1=1, FwdData1=0x20; RS2=0 -> Hit2=0, FwdData2=0.
REQ-037 x0 drop: push rd=0, data=0xFF -> Count stays 0, RegWrite stays 0.
REQ-038 Wrap and simultaneous: WbStall=0, push every cycle for 10 cycles with rd=1..10 -> Count holds at 1, writes in order, pointers wrap without loss.
REQ-039 Reset mid-operation: 3 entries queued, assert Reset one cycle -> Count=0, RegWrite=0, Hit1=0 for a previously matching RS1.
